// File: rtl/rd_req_dispatcher.sv
// rd_req_dispatcher: captures a READ request and writes it into the
// target read-request FIFO chosen by the top address bits.
//
// Ports:
//   aclk, areset   clock, asynchronous active-high reset
//   req, addr, cmd requester level request, address, 0=READ/1=write
//   ack, err       one-cycle pulses: written / dropped on timeout
//   busy           request in flight (settle or write phase)
//   rd_addr        captured address presented to the FIFOs
//   rd_wren        one-hot FIFO write enable
//   rd_fifo_full   per-target FIFO full flags
module rd_req_dispatcher #(
   parameter int AWIDTH    = 32,
   parameter int NUM_TGT   = 2,
   parameter int DELAY_MAX = 3,
   parameter int TIMEOUT   = 255
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic               req,
   input  logic [AWIDTH-1:0]  addr,
   input  logic               cmd,
   output logic               ack,
   output logic               err,
   output logic               busy,
   output logic [AWIDTH-1:0]  rd_addr,
   output logic [NUM_TGT-1:0] rd_wren,
   input  logic [NUM_TGT-1:0] rd_fifo_full
);

   localparam int TSEL = $clog2(NUM_TGT);
   localparam int DW   = $clog2(DELAY_MAX + 1);
   localparam int WW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [DW-1:0] DLY_END = DW'(DELAY_MAX);
   localparam logic [DW-1:0] DLY_INC = DW'(1);
   localparam logic [WW-1:0] WT_END  = WW'(TIMEOUT);
   localparam logic [WW-1:0] WT_INC  = WW'(1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REQ_HIGH,
      WAIT_FIFO_STATUS,
      WRITE_REQ,
      WAIT_REQ_LOW
   } state_t;

   state_t              state_q, state_d;
   logic                armed_q;
   logic [DW-1:0]       dly_q, dly_d;
   logic [WW-1:0]       wait_q, wait_d;
   logic [NUM_TGT-1:0]  full_q;
   logic [TSEL-1:0]     tgt_q;
   logic                load;
   logic                full_sel;
   logic [NUM_TGT-1:0]  wren_d;
   logic                ack_d;
   logic                err_d;

   assign full_sel = full_q[tgt_q];
   assign busy     = (state_q == WAIT_FIFO_STATUS) ||
                     (state_q == WRITE_REQ);

   always_comb begin
      state_d = state_q;
      dly_d   = '0;
      wait_d  = '0;
      wren_d  = '0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         // armed_q holds IDLE for one extra edge after reset release
         IDLE: begin
            if (armed_q)
               state_d = WAIT_REQ_HIGH;
         end
         WAIT_REQ_HIGH: begin
            load = 1'b1;
            if (req && !cmd)
               state_d = WAIT_FIFO_STATUS;
         end
         WAIT_FIFO_STATUS: begin
            if (dly_q == DLY_END)
               state_d = WRITE_REQ;
            else
               dly_d = dly_q + DLY_INC;
         end
         // a free FIFO wins over an expiring timeout
         WRITE_REQ: begin
            if (!full_sel) begin
               state_d        = WAIT_REQ_LOW;
               wren_d[tgt_q]  = 1'b1;
               ack_d          = 1'b1;
            end else if (TIMEOUT != 0 && wait_q == WT_END) begin
               state_d = WAIT_REQ_LOW;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + WT_INC;
            end
         end
         WAIT_REQ_LOW: begin
            if (!req)
               state_d = WAIT_REQ_HIGH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
         dly_q   <= '0;
         wait_q  <= '0;
         full_q  <= '0;
         tgt_q   <= '0;
         rd_addr <= '0;
         rd_wren <= '0;
         ack     <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         dly_q   <= dly_d;
         wait_q  <= wait_d;
         full_q  <= rd_fifo_full;
         if (load) begin
            rd_addr <= addr;
            tgt_q   <= addr[AWIDTH-1 -: TSEL];
         end
         rd_wren <= wren_d;
         ack     <= ack_d;
         err     <= err_d;
      end
   end

endmodule

// File: tb/tb_rd_req_dispatcher.sv
// tb_rd_req_dispatcher: directed stimulus, transaction-level model
// and per-cycle compare for rd_req_dispatcher.
module tb_rd_req_dispatcher;

   localparam int AW = 32;
   localparam int NT = 4;
   localparam int TS = 2;
   localparam int DM = 3;
   localparam int TO = 8;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          req = 1'b0;
   logic          cmd = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [NT-1:0] rd_fifo_full = '0;
   logic          ack, err, busy;
   logic [AW-1:0] rd_addr;
   logic [NT-1:0] rd_wren;

   rd_req_dispatcher #(
      .AWIDTH(AW), .NUM_TGT(NT), .DELAY_MAX(DM), .TIMEOUT(TO)
   ) dut (
      .aclk(aclk), .areset(areset), .req(req), .addr(addr),
      .cmd(cmd), .ack(ack), .err(err), .busy(busy),
      .rd_addr(rd_addr), .rd_wren(rd_wren),
      .rd_fifo_full(rd_fifo_full)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_fails  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Model: edges are counted from reset release. The block accepts
   // requests from edge 3, writes at capture+DM+2 once the FIFO
   // flag seen one edge earlier is clear, or gives up after TO
   // further full edges; then needs req low before re-accepting.
   int            m_cyc, m_cap, m_idx, m_j;
   bit            m_listen, m_infl, m_low;
   logic [NT-1:0] m_pfull;
   logic [NT-1:0] e_wren;
   bit            e_ack, e_err, e_busy;
   logic [AW-1:0] e_addr;

   always @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_cyc = 0; m_cap = 0; m_idx = 0;
         m_listen = 0; m_infl = 0; m_low = 0;
         m_pfull = '0; e_wren = '0;
         e_ack = 0; e_err = 0; e_busy = 0; e_addr = '0;
      end else begin
         m_cyc++;
         e_wren = '0; e_ack = 0; e_err = 0;
         if (m_infl) begin
            m_j = m_cyc - (m_cap + DM + 2);
            if (m_j >= 0) begin
               if (!m_pfull[m_idx]) begin
                  e_wren[m_idx] = 1'b1;
                  e_ack = 1; m_infl = 0; m_low = 1;
               end else if (TO != 0 && m_j == TO) begin
                  e_err = 1; m_infl = 0; m_low = 1;
               end
            end
         end else if (m_low) begin
            if (!req) begin m_low = 0; m_listen = 1; end
         end else if (m_listen) begin
            e_addr = addr;
            if (req && !cmd) begin
               m_infl = 1; m_listen = 0; m_cap = m_cyc;
               m_idx = int'(addr[AW-1 -: TS]);
            end
         end else if (m_cyc == 2) begin
            m_listen = 1;
         end
         e_busy = m_infl;
         m_pfull = rd_fifo_full;
      end
   end

   int            n_wren = 0;
   int            n_errp = 0;
   bit            busy_seen = 0;
   logic [NT-1:0] last_wren = '0;

   always @(negedge aclk) begin
      if (areset) begin
         chk("reset_outs", {rd_wren, ack, err, busy}, 32'd0);
      end else begin
         chk("wren", 32'(rd_wren), 32'(e_wren));
         chk("ack", 32'(ack), 32'(e_ack));
         chk("err", 32'(err), 32'(e_err));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("rd_addr", rd_addr, e_addr);
         chk("ack_err_excl", 32'(ack & err), 32'd0);
         if (rd_wren != '0) begin
            n_wren++;
            last_wren = rd_wren;
         end
         if (err) n_errp++;
         if (busy) busy_seen = 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge aclk);
         #1;
      end
   endtask

   int k, w0, e0;

   initial begin
      tick(3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", rd_addr, 32'd0);
      chk("rst_wren", 32'(rd_wren), 32'd0);

      // basic write, latency from reset release
      addr = 32'hC000_0010; req = 1; cmd = 0;
      areset = 0;
      k = 0;
      do begin
         tick(1);
         k++;
      end while (rd_wren == '0 && k < 40);
      chk("lat_edges", k, 8);
      chk("lat_wren", 32'(rd_wren), 32'h8);
      chk("lat_ack", 32'(ack), 32'd1);
      chk("lat_addr", rd_addr, 32'hC000_0010);
      tick(1);
      chk("ack_pulse", 32'(ack), 32'd0);

      // req held: single write until req falls and rises
      w0 = n_wren;
      tick(10);
      chk("hold_one", n_wren, w0);
      req = 0; tick(1);
      req = 1; tick(12);
      chk("rearm", n_wren, w0 + 1);
      req = 0; tick(3);

      // write commands ignored
      busy_seen = 0; w0 = n_wren;
      cmd = 1; req = 1; tick(20);
      chk("wcmd_wren", n_wren, w0);
      chk("wcmd_busy", 32'(busy_seen), 32'd0);
      req = 0; cmd = 0; tick(2);

      // full for 10 cycles, inputs disturbed after capture
      w0 = n_wren; e0 = n_errp;
      addr = 32'h4000_0000; rd_fifo_full = 4'b0010; req = 1;
      tick(1);
      req = 0; cmd = 1; addr = 32'h8000_0000;
      chk("full_busy", 32'(busy), 32'd1);
      tick(9);
      rd_fifo_full = '0; cmd = 0;
      tick(6);
      chk("full_wr", n_wren, w0 + 1);
      chk("full_tgt", 32'(last_wren), 32'h2);
      chk("full_noerr", n_errp, e0);

      // permanent full: timeout
      w0 = n_wren; e0 = n_errp;
      addr = 32'h8000_0000; rd_fifo_full = 4'b0100; req = 1;
      tick(30);
      chk("to_err", n_errp, e0 + 1);
      chk("to_nowr", n_wren, w0);
      chk("to_idle", 32'(busy), 32'd0);
      rd_fifo_full = '0; tick(10);
      chk("to_waitlow", n_wren, w0);
      req = 0; tick(2);

      // full clears exactly at the timeout edge: write wins
      w0 = n_wren; e0 = n_errp;
      rd_fifo_full = 4'b0100; req = 1;
      tick(1);
      tick(11);
      rd_fifo_full = '0; tick(6);
      chk("edge_wr", n_wren, w0 + 1);
      chk("edge_noerr", n_errp, e0);
      req = 0; tick(2);

      // full clears one edge later: timeout wins
      w0 = n_wren; e0 = n_errp;
      rd_fifo_full = 4'b0100; req = 1;
      tick(1);
      tick(12);
      rd_fifo_full = '0; tick(6);
      chk("late_err", n_errp, e0 + 1);
      chk("late_nowr", n_wren, w0);
      req = 0; tick(2);

      // reset one cycle after capture
      w0 = n_wren;
      addr = 32'hC000_0010; req = 1;
      tick(1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      @(posedge aclk); #1;
      areset = 1; #1;
      chk("arst_outs", {rd_wren, ack, err, busy}, 32'd0);
      chk("arst_addr", rd_addr, 32'd0);
      tick(2);
      areset = 0; req = 0;
      tick(15);
      chk("arst_nowr", n_wren, w0);
      req = 1; tick(12);
      chk("arst_new", n_wren, w0 + 1);
      req = 0; tick(3);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
